// File: rtl/sha2_pkg.sv
// SHA-2 shared definitions: word types, FSM states, IV and round constant tables,
// and the sigma/compression helpers for both 32-bit and 64-bit word widths.
// Pure package; no state.
package sha2_pkg;

  typedef logic [31:0] sha_word32_t;
  typedef logic [63:0] sha_word64_t;
  typedef logic [7:0][31:0] sha_wv32_t;  // working vars, index 0 = a
  typedef logic [7:0][63:0] sha_wv64_t;

  typedef enum logic [1:0] {Idle, Fill, Round, Update} sha2_st_e;

  localparam sha_word32_t InitHash256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam sha_word32_t InitHash224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
  localparam sha_word64_t InitHash512 [8] = '{
    64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
    64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
  localparam sha_word64_t InitHash384 [8] = '{
    64'hcbbb9d5dc1059ed8, 64'h629a292a367cd507, 64'h9159015a3070dd17, 64'h152fecd8f70e5939,
    64'h67332667ffc00b31, 64'h8eb44a8768581511, 64'hdb0c2e0d64f98fa7, 64'h47b5481dbefa4fa4};

  localparam sha_word32_t K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam sha_word64_t K512 [80] = '{
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

  // Rotate right within the low w bits of a 64-bit container (w = 32 or 64).
  function automatic sha_word64_t rotr(input sha_word64_t x, input int unsigned n, input int unsigned w);
    sha_word64_t m;
    m = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic sha_word64_t shiftr(input sha_word64_t x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic sha_wv32_t compress32(input sha_word32_t w, input sha_word32_t k, input sha_wv32_t v);
    sha_word64_t a, e;
    sha_word32_t s0, s1, ch, mj, t1, t2;
    sha_wv32_t n;
    a  = 64'(v[0]);
    e  = 64'(v[4]);
    s0 = sha_word32_t'(rotr(a, 2, 32) ^ rotr(a, 13, 32) ^ rotr(a, 22, 32));
    s1 = sha_word32_t'(rotr(e, 6, 32) ^ rotr(e, 11, 32) ^ rotr(e, 25, 32));
    ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
    mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t1 = v[7] + s1 + ch + k + w;
    t2 = s0 + mj;
    n  = {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
    return n;
  endfunction

  function automatic sha_wv64_t compress64(input sha_word64_t w, input sha_word64_t k, input sha_wv64_t v);
    sha_word64_t s0, s1, ch, mj, t1, t2;
    sha_wv64_t n;
    s0 = rotr(v[0], 28, 64) ^ rotr(v[0], 34, 64) ^ rotr(v[0], 39, 64);
    s1 = rotr(v[4], 14, 64) ^ rotr(v[4], 18, 64) ^ rotr(v[4], 41, 64);
    ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
    mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
    t1 = v[7] + s1 + ch + k + w;
    t2 = s0 + mj;
    n  = {v[6], v[5], v[4], v[3] + t1, v[2], v[1], v[0], t1 + t2};
    return n;
  endfunction

  // Next schedule word from the window {w0, w1, w9, w14} = W[t-16], W[t-15], W[t-7], W[t-2].
  function automatic sha_word32_t calc_w32(input sha_word32_t w0, input sha_word32_t w1,
                                           input sha_word32_t w9, input sha_word32_t w14);
    sha_word64_t x1, x14;
    x1  = 64'(w1);
    x14 = 64'(w14);
    return sha_word32_t'((rotr(x14, 17, 32) ^ rotr(x14, 19, 32) ^ shiftr(x14, 10)) + 64'(w9)
                         + (rotr(x1, 7, 32) ^ rotr(x1, 18, 32) ^ shiftr(x1, 3)) + 64'(w0));
  endfunction

  function automatic sha_word64_t calc_w64(input sha_word64_t w0, input sha_word64_t w1,
                                           input sha_word64_t w9, input sha_word64_t w14);
    return (rotr(w14, 19, 64) ^ rotr(w14, 61, 64) ^ shiftr(w14, 6)) + w9
           + (rotr(w1, 1, 64) ^ rotr(w1, 8, 64) ^ shiftr(w1, 7)) + w0;
  endfunction

endpackage

// File: rtl/sha2_msg_sched.sv
// SHA-2 message schedule: 16-word sliding window, fed by the message stream during
// fill and extended by calc_w during rounds. w0 is the word consumed this round.
// No handshake of its own; the parent decides when to load or step.
module sha2_msg_sched
  import sha2_pkg::*;
#(
  parameter int WordW = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WordW-1:0] word,
  output logic [WordW-1:0] w0
);

  logic [15:0][WordW-1:0] w;
  logic [WordW-1:0]       w_new;

  if (WordW == 32) begin : g_w32
    assign w_new = calc_w32(w[0], w[1], w[9], w[14]);
  end else begin : g_w64
    assign w_new = calc_w64(w[0], w[1], w[9], w[14]);
  end

  // Shift window down by one: new word from the stream (fill) or from calc_w (round).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w <= '0;
    end else if (load) begin
      w <= {word, w[15:1]};
    end else if (step) begin
      w <= {w_new, w[15:1]};
    end
  end

  assign w0 = w[0];

endmodule

// File: rtl/sha2_core.sv
// Iterative SHA-2 compression engine (WordW=32: SHA-256/224, WordW=64: SHA-512/384).
// Latency 16 + NumRound + 1 cycles per block from first word; one round per cycle.
// msg_ready_o high only in Fill. Optional byte swap of input words: SHA2_ENDIAN_SWAP_EN.
module sha2_core
  import sha2_pkg::*;
#(
  parameter int WordW = 32
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               trunc_i,
  input  logic               msg_valid_i,
  input  logic [WordW-1:0]   msg_word_i,
  input  logic               msg_last_i,
  output logic               msg_ready_o,
  output logic               busy_o,
  output logic               digest_valid_o,
  output logic [8*WordW-1:0] digest_o,
  output logic               err_o
);

  localparam int NumRound = (WordW == 32) ? 64 : 80;

  if (!(WordW == 32 || WordW == 64)) begin : g_bad_width
    $error("sha2_core: WordW must be 32 or 64");
  end

  sha2_st_e               st, st_nxt;
  logic [7:0][WordW-1:0]  h, wv, wv_nxt, init_h;
  logic [3:0]             cnt;
  logic [6:0]             rnd;
  logic                   last, trunc, dvld, err;
  logic [WordW-1:0]       word_in, w0, k_r;
  logic                   hs;

  assign hs = msg_valid_i && (st == Fill);

`ifdef SHA2_ENDIAN_SWAP_EN
  // Byte-reverse each word so a little-endian bus feeds the big-endian schedule.
  always_comb begin
    word_in = '0;
    for (int b = 0; b < WordW / 8; b++) begin
      word_in[b*8 +: 8] = msg_word_i[(WordW/8-1-b)*8 +: 8];
    end
  end
`else
  assign word_in = msg_word_i;
`endif

  if (WordW == 32) begin : g_c32
    assign k_r    = K256[rnd[5:0]];
    assign wv_nxt = compress32(w0, k_r, wv);
    // IV select for SHA-256 vs SHA-224.
    always_comb begin
      for (int i = 0; i < 8; i++) init_h[i] = trunc_i ? InitHash224[i] : InitHash256[i];
    end
  end else begin : g_c64
    assign k_r    = K512[rnd];
    assign wv_nxt = compress64(w0, k_r, wv);
    // IV select for SHA-512 vs SHA-384.
    always_comb begin
      for (int i = 0; i < 8; i++) init_h[i] = trunc_i ? InitHash384[i] : InitHash512[i];
    end
  end

  sha2_msg_sched #(.WordW(WordW)) u_sched (
    .clk  (clk_i),
    .rst  (rst_i),
    .load (hs),
    .step (st == Round),
    .word (word_in),
    .w0   (w0)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) st <= Idle;
    else       st <= st_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    st_nxt      = st;
    msg_ready_o = 1'b0;
    busy_o      = (st != Idle);
    unique case (st)
      Idle:   if (start_i) st_nxt = Fill;
      Fill: begin
        msg_ready_o = 1'b1;
        if (hs && cnt == 4'd15) st_nxt = Round;
      end
      Round:  if (rnd == 7'(NumRound - 1)) st_nxt = Update;
      Update: st_nxt = last ? Idle : Fill;
      default: st_nxt = Idle;
    endcase
  end

  // Hash state, working vars, counters and digest-valid flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h     <= '0;
      wv    <= '0;
      cnt   <= '0;
      rnd   <= '0;
      last  <= 1'b0;
      trunc <= 1'b0;
      dvld  <= 1'b0;
    end else begin
      unique case (st)
        Idle: if (start_i) begin
          h     <= init_h;
          trunc <= trunc_i;
          dvld  <= 1'b0;
          cnt   <= '0;
        end
        Fill: if (hs) begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            last <= msg_last_i;
            wv   <= h;
            rnd  <= '0;
          end
        end
        Round: begin
          wv  <= wv_nxt;
          rnd <= rnd + 7'd1;
        end
        Update: begin
          for (int i = 0; i < 8; i++) h[i] <= h[i] + wv[i];
          cnt <= '0;
          if (last) dvld <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Protocol violations: a word offered in Idle, or a start while busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err <= 1'b0;
    else       err <= ((st == Idle) && msg_valid_i && !start_i) || ((st != Idle) && start_i);
  end

  assign err_o          = err;
  assign digest_valid_o = dvld;

  // Digest only visible once complete; H0 at the MSBs, truncated words forced to 0.
  always_comb begin
    digest_o = '0;
    if (dvld) begin
      for (int i = 0; i < 8; i++) begin
        if (!(trunc && (i == 7 || (WordW == 64 && i == 6)))) digest_o[(7-i)*WordW +: WordW] = h[i];
      end
    end
  end

endmodule
